// File: rtl/mem_io_pkg.sv
// Shared constants and decode helpers for the cpu memory bus responder.
package mem_io_pkg;

  // Byte width of the cpu data bus, shared with the cpu core.
  localparam int DataLength = 8;

  localparam logic [1:0]  IO_SEL    = 2'b11;
  localparam logic [17:0] IO_UART   = 18'h30000;
  localparam logic [17:0] IO_CLK    = 18'h30004;
  localparam logic [17:0] IO_CLK_B1 = 18'h30005;
  localparam logic [17:0] IO_CLK_B2 = 18'h30006;
  localparam logic [17:0] IO_CLK_B3 = 18'h30007;

  typedef enum logic [2:0] {
    RD_RAM,
    RD_RX,
    RD_CLK0,
    RD_CLK1,
    RD_CLK2,
    RD_CLK3,
    RD_ZERO
  } rd_sel_e;

  // Classify a decoded 18-bit address into the source of its read data.
  function automatic rd_sel_e io_rd_sel(input logic [17:0] a);
    if (a[17:16] != IO_SEL) return RD_RAM;
    case (a)
      IO_UART:   return RD_RX;
      IO_CLK:    return RD_CLK0;
      IO_CLK_B1: return RD_CLK1;
      IO_CLK_B2: return RD_CLK2;
      IO_CLK_B3: return RD_CLK3;
      default:   return RD_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// cpu byte-wide memory bus: cpu side drives address/write, responder answers.
interface mem_io_responder_if import mem_io_pkg::*; ();
  logic [31:0]           mem_a;
  logic                  mem_wr;
  logic [DataLength-1:0] mem_dout;
  logic [DataLength-1:0] mem_din;
  logic                  io_buffer_full;

  modport master (output mem_a, mem_wr, mem_dout, input mem_din, io_buffer_full);
  modport slave  (input mem_a, mem_wr, mem_dout, output mem_din, io_buffer_full);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees the head slot.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  // Pointer update; the only state that needs reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the cpu memory bus: RAM, UART queues, cycle counter, halt.
module mem_io_responder import mem_io_pkg::*; #(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  mem_io_responder_if.slave     bus,
  output logic [DataLength-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DataLength-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  halted,
  output logic                  tx_overflow
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  // Contents are loaded externally before the run and survive reset.
  logic [DataLength-1:0] ram [2**RAM_ADDR_W];

  logic [17:0]           addr18;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  is_io;
  rd_sel_e               rd_sel;
  logic                  unused_hi;

  logic                  ram_we;
  logic                  tx_push_req;
  logic [DataLength-1:0] tx_push_dat;
  logic                  halt_set;
  logic                  rx_pop_req;
  logic                  snap_ld;

  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_full;
  logic                  tx_empty;
  logic [TCW-1:0]        tx_count;
  logic [TCW-1:0]        tx_cnt_nxt;

  logic                  rx_push;
  logic                  rx_pop;
  logic                  rx_full;
  logic                  rx_empty;
  logic [DataLength-1:0] rx_head;
  logic [RCW-1:0]        rx_count;

  logic [31:0]           counter;
  logic [31:0]           snapshot;
  logic [DataLength-1:0] io_rd;

  assign addr18    = bus.mem_a[17:0];
  assign ram_addr  = bus.mem_a[RAM_ADDR_W-1:0];
  assign is_io     = (addr18[17:16] == IO_SEL);
  assign rd_sel    = io_rd_sel(addr18);
  assign unused_hi = ^{bus.mem_a[31:18], rx_count};

  // Decode the current bus cycle into write/read side effects.
  always_comb begin
    ram_we      = 1'b0;
    tx_push_req = 1'b0;
    tx_push_dat = '0;
    halt_set    = 1'b0;
    rx_pop_req  = 1'b0;
    snap_ld     = 1'b0;
    if (bus.mem_wr) begin
      if (!is_io) begin
        ram_we = 1'b1;
      end else if (addr18 == IO_UART) begin
        // A zero byte on the UART port is a no-op, not a character.
        tx_push_req = (bus.mem_dout != '0);
        tx_push_dat = bus.mem_dout;
      end else if (addr18 == IO_CLK) begin
        // Stop request: raise halt and queue a 0x00 marker for the host.
        halt_set    = 1'b1;
        tx_push_req = 1'b1;
        tx_push_dat = '0;
      end
    end else begin
      rx_pop_req = (rd_sel == RD_RX);
      snap_ld    = (rd_sel == RD_CLK0);
    end
  end

  assign tx_valid   = ~tx_empty;
  assign tx_pop     = tx_valid & tx_ready;
  assign tx_push    = tx_push_req & (~tx_full | tx_pop);
  assign tx_cnt_nxt = tx_count + TCW'(tx_push) - TCW'(tx_pop);

  assign rx_ready   = ~rx_full;
  assign rx_push    = rx_valid & rx_ready;
  assign rx_pop     = rx_pop_req & ~rx_empty;

  sync_fifo #(.WIDTH(DataLength), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push),
    .din    (tx_push_dat),
    .pop    (tx_pop),
    .dout   (tx_data),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  sync_fifo #(.WIDTH(DataLength), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rx_push),
    .din    (rx_data),
    .pop    (rx_pop),
    .dout   (rx_head),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

  // Read data for IO addresses; an empty RX queue reads as 0x00.
  always_comb begin
    io_rd = '0;
    case (rd_sel)
      RD_RX:   io_rd = rx_empty ? '0 : rx_head;
      RD_CLK0: io_rd = counter[7:0];
      RD_CLK1: io_rd = snapshot[15:8];
      RD_CLK2: io_rd = snapshot[23:16];
      RD_CLK3: io_rd = snapshot[31:24];
      default: io_rd = '0;
    endcase
  end

  // RAM byte write, no reset so contents persist.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= bus.mem_dout;
  end

  // Snapshot the full counter when its low byte is read, so the upper bytes
  // read on later cycles are coherent with it.
  always_ff @(posedge clk_in) begin
    if (snap_ld) snapshot <= counter;
  end

  // Registered read response, counter, halt and sticky status flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.mem_din        <= '0;
      bus.io_buffer_full <= 1'b0;
      counter            <= '0;
      halted             <= 1'b0;
      tx_overflow        <= 1'b0;
    end else begin
      if (bus.mem_wr)            bus.mem_din <= '0;
      else if (rd_sel == RD_RAM) bus.mem_din <= ram[ram_addr];
      else                       bus.mem_din <= io_rd;
      // Two entries of margin cover the cpu's one-cycle reaction latency.
      bus.io_buffer_full <= (tx_cnt_nxt >= TCW'(TX_DEPTH - 2));
      if (!halted) counter <= counter + 32'd1;
      if (halt_set) halted <= 1'b1;
      if (tx_push_req && tx_full && !tx_pop) tx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: vector table plus corner sequences.
module tb_mem_io_responder;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       halted;
  logic       tx_overflow;

  mem_io_responder_if bif ();

  mem_io_responder #(.RAM_ADDR_W(17), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .bus         (bif),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .halted      (halted),
    .tx_overflow (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] mcnt   = 0;
  logic        mhalt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock edge; the counter model follows the inputs sampled at the edge.
  task automatic cyc();
    @(posedge clk_in);
    if (rst_in) begin
      mcnt  = 0;
      mhalt = 0;
    end else begin
      if (!mhalt) mcnt = mcnt + 1;
      if (bif.mem_wr && bif.mem_a[17:0] == 18'h30004) mhalt = 1;
    end
    #1;
  endtask

  task automatic setbus(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bif.mem_wr   = wr;
    bif.mem_a    = a;
    bif.mem_dout = d;
  endtask

  task automatic idle();
    setbus(1'b0, 32'h0003_0008, 8'h00);
  endtask

  vec_t        vt [12];
  logic [31:0] exp_cnt;
  logic [31:0] snap;
  logic [7:0]  b0, b1, b2, b3;

  initial begin
    vt[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'hA5};
    vt[2]  = '{1'b1, 32'h0000_0011, 8'h5C, 1'b0, 8'h00};
    vt[3]  = '{1'b0, 32'h0000_0011, 8'h00, 1'b1, 8'h5C};
    vt[4]  = '{1'b1, 32'hFFFC_0020, 8'h3A, 1'b0, 8'h00};
    vt[5]  = '{1'b0, 32'h0000_0020, 8'h00, 1'b1, 8'h3A};
    vt[6]  = '{1'b1, 32'h0002_FFFF, 8'hC3, 1'b0, 8'h00};
    vt[7]  = '{1'b0, 32'h0000_FFFF, 8'h00, 1'b1, 8'hC3};
    vt[8]  = '{1'b1, 32'h0003_0008, 8'h99, 1'b0, 8'h00};
    vt[9]  = '{1'b0, 32'h0003_0008, 8'h00, 1'b1, 8'h00};
    vt[10] = '{1'b1, 32'h0001_0000, 8'h7E, 1'b0, 8'h00};
    vt[11] = '{1'b0, 32'h0001_0000, 8'h00, 1'b1, 8'h7E};

    rst_in   = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle();
    cyc();
    cyc();
    rst_in = 1'b0;

    chk("reset mem_din", bif.mem_din, 0);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset io_buffer_full", bif.io_buffer_full, 0);
    chk("reset halted", halted, 0);
    chk("reset tx_overflow", tx_overflow, 0);
    chk("reset rx_ready", rx_ready, 1);

    // Clock read at cycle 300 after reset, then the snapshot bytes.
    repeat (300) cyc();
    exp_cnt = mcnt;
    setbus(1'b0, 32'h0003_0004, 8'h00); cyc(); b0 = bif.mem_din;
    setbus(1'b0, 32'h0003_0005, 8'h00); cyc(); b1 = bif.mem_din;
    setbus(1'b0, 32'h0003_0006, 8'h00); cyc(); b2 = bif.mem_din;
    setbus(1'b0, 32'h0003_0007, 8'h00); cyc(); b3 = bif.mem_din;
    snap = {b3, b2, b1, b0};
    chk("clock snapshot", snap, exp_cnt);
    idle();
    repeat (20) cyc();
    setbus(1'b0, 32'h0003_0005, 8'h00); cyc();
    chk("clock snapshot held", bif.mem_din, {24'h0, exp_cnt[15:8]});
    idle();

    // RAM and decode vectors: each row's read data is checked one edge later.
    for (int i = 0; i < 12; i++) begin
      setbus(vt[i].wr, vt[i].a, vt[i].d);
      cyc();
      if (vt[i].chk) chk($sformatf("vector %0d mem_din", i), bif.mem_din, {24'h0, vt[i].exp});
    end
    idle();

    // UART out: zero byte must never reach the queue.
    tx_ready = 1'b1;
    setbus(1'b1, 32'h0003_0000, 8'h48); cyc();
    chk("uart out first valid", tx_valid, 1);
    chk("uart out first data", tx_data, 8'h48);
    setbus(1'b1, 32'h0003_0000, 8'h00); cyc();
    chk("uart out zero dropped", tx_valid, 0);
    setbus(1'b1, 32'h0003_0000, 8'h49); cyc();
    chk("uart out second valid", tx_valid, 1);
    chk("uart out second data", tx_data, 8'h49);
    idle(); cyc();
    chk("uart out drained", tx_valid, 0);

    // Backpressure: fill, watch the early-full flag, overflow on the 9th.
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      setbus(1'b1, 32'h0003_0000, 8'h61 + 8'(i));
      cyc();
      if (i == 4) chk("io_buffer_full after 5", bif.io_buffer_full, 0);
      if (i == 5) chk("io_buffer_full after 6", bif.io_buffer_full, 1);
      if (i == 7) chk("tx_overflow after 8", tx_overflow, 0);
      if (i == 8) chk("tx_overflow after 9", tx_overflow, 1);
    end
    idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain %0d valid", i), tx_valid, 1);
      chk($sformatf("drain %0d data", i), tx_data, 8'h61 + 8'(i));
      cyc();
    end
    chk("drain empty", tx_valid, 0);
    chk("drain io_buffer_full", bif.io_buffer_full, 0);

    // UART in: two bytes, then three reads.
    rx_valid = 1'b1; rx_data = 8'h31; cyc();
    rx_data = 8'h32; cyc();
    rx_valid = 1'b0;
    setbus(1'b0, 32'h0003_0000, 8'h00);
    cyc(); chk("uart in byte 1", bif.mem_din, 8'h31);
    cyc(); chk("uart in byte 2", bif.mem_din, 8'h32);
    cyc(); chk("uart in empty", bif.mem_din, 8'h00);
    // Pop from empty while a byte arrives: 0x00 now, the byte next time.
    rx_valid = 1'b1; rx_data = 8'h77; cyc();
    chk("uart in pop during push", bif.mem_din, 8'h00);
    rx_valid = 1'b0; cyc();
    chk("uart in pushed byte kept", bif.mem_din, 8'h77);
    idle();
    // Fill the RX queue until rx_ready drops; a ninth byte is refused.
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'h80 + 8'(i);
      cyc();
    end
    rx_valid = 1'b0;
    chk("rx full rx_ready", rx_ready, 0);
    setbus(1'b0, 32'h0003_0000, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("rx drain %0d", i), bif.mem_din, 8'h80 + 8'(i));
    end
    cyc();
    chk("rx drain empty", bif.mem_din, 8'h00);
    chk("rx drain rx_ready", rx_ready, 1);
    idle();

    // Halt: marker byte, frozen counter, RAM still readable.
    setbus(1'b1, 32'h0003_0004, 8'h55); cyc();
    chk("halt halted", halted, 1);
    chk("halt marker valid", tx_valid, 1);
    chk("halt marker data", tx_data, 8'h00);
    idle(); cyc();
    chk("halt marker popped", tx_valid, 0);
    exp_cnt = mcnt;
    setbus(1'b0, 32'h0003_0004, 8'h00); cyc();
    chk("halt counter low", bif.mem_din, {24'h0, exp_cnt[7:0]});
    idle(); repeat (5) cyc();
    setbus(1'b0, 32'h0003_0004, 8'h00); cyc();
    chk("halt counter frozen", bif.mem_din, {24'h0, mcnt[7:0]});
    setbus(1'b0, 32'h0003_0005, 8'h00); cyc();
    chk("halt counter byte1", bif.mem_din, {24'h0, mcnt[15:8]});
    setbus(1'b0, 32'h0000_0010, 8'h00); cyc();
    chk("halt ram read", bif.mem_din, 8'hA5);

    // Reset with a read pending drops the result and clears halt.
    setbus(1'b0, 32'h0000_0010, 8'h00);
    rst_in = 1'b1; cyc();
    rst_in = 1'b0;
    chk("reset drops read", bif.mem_din, 0);
    chk("reset clears halted", halted, 0);
    chk("reset clears tx_overflow", tx_overflow, 0);
    setbus(1'b0, 32'h0003_0004, 8'h00); cyc();
    chk("reset counter", bif.mem_din, {24'h0, 8'h00});
    setbus(1'b0, 32'h0000_0011, 8'h00); cyc();
    chk("ram kept over reset", bif.mem_din, 8'h5C);
    idle(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the cpu byte-wide memory bus (mem_a / mem_wr / mem_dout / mem_din / io_buffer_full).
- Holds the program/data RAM and the memory-mapped I/O page, with a UART transmit queue, a UART receive queue, a cycle counter and a halt flag.
- Sits beside cpu in the sim/FPGA top. Every read is answered one cycle after the address is presented, and every write completes in one cycle.

Parameters:
- RAM_ADDR_W, 17, RAM byte-address width (128 KB).
- TX_DEPTH, 8, TX FIFO entries (power of 2, at least 4).
- RX_DEPTH, 8, RX FIFO entries (power of 2).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- mem_a  in  32  byte address from cpu; only bits 17:0 are decoded.
- mem_wr  in  1  1 = write this cycle, 0 = read.
- mem_dout  in  8  write data from cpu.
- mem_din  out  8  read data to cpu, valid the cycle after the address.
- io_buffer_full  out  1  TX queue nearly full; cpu must not write 0x30000.
- tx_data  out  8  byte toward UART tx.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts tx_data this cycle.
- rx_data  in  8  byte from UART rx.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  RX FIFO can accept a byte.
- halted  out  1  program-stop seen (sticky).
- tx_overflow  out  1  sticky: a TX byte was dropped because the FIFO was full.

Behaviour:
- Clocking and reset: one clock, clk_in. Reset is synchronous, active-high, on rst_in.
- Reset values:
  - mem_din = 0, tx_valid = 0, io_buffer_full = 0, halted = 0, tx_overflow = 0, rx_ready = 1.
  - Both FIFOs are emptied and the cycle counter is set to 0.
  - RAM contents are preserved (preloaded by $readmemh at elaboration).
  - Reset mid-operation drops any pending read result; mem_din is 0 on the next cycle.
- Address decode: IO when mem_a[17:16] == 2'b11; otherwise RAM at mem_a[RAM_ADDR_W-1:0].
- RAM write (mem_wr = 1, RAM address): the byte is written at the clock edge.
- RAM read: mem_din <= ram[addr] at the edge, so the data is visible in the following cycle.
  - Read-after-write to the same address in consecutive cycles returns the new data.
- IO writes:
  - 0x30000, data != 0: push into the TX FIFO.
    - If the FIFO is full, drop the byte and set tx_overflow.
  - 0x30000, data == 0: ignored.
  - 0x30004: set halted and push 0x00 into the TX FIFO (the stop marker).
  - Other IO addresses: ignored.
- IO reads (result registered, same 1-cycle latency as RAM):
  - 0x30000: pop the RX FIFO and return its head. If the RX FIFO is empty, return 0x00 with no pop.
  - 0x30004: return counter[7:0] and latch the whole 32-bit counter into a snapshot register.
  - 0x30005 / 0x30006 / 0x30007: return snapshot bytes [15:8] / [23:16] / [31:24].
  - Other IO addresses: return 0x00.
- Cycle counter:
  - 32-bit, increments every cycle while halted = 0 and wraps from 0xFFFFFFFF to 0.
  - Freezes once halted = 1.
- TX side:
  - tx_valid = TX FIFO not empty; tx_data = FIFO head.
  - The FIFO pops when tx_valid && tx_ready.
  - A push and a pop in the same cycle keep the count unchanged, including when the FIFO is full (push accepted, no overflow).
- io_buffer_full:
  - Registered; equals (TX count after this cycle's updates) >= TX_DEPTH-2.
  - The two-entry margin covers the cpu's one-cycle reaction latency.
- RX side:
  - rx_ready = RX FIFO not full.
  - The FIFO pushes when rx_valid && rx_ready.
  - A simultaneous push and pop (0x30000 read) are both honoured.
  - A pop from a previously empty FIFO during a push returns 0x00; the pushed byte stays in the FIFO.
- halted:
  - Stays 1 until reset.
  - RAM and IO accesses keep working after halt so the bench can dump memory.

Decomposition:
- Package mem_io_pkg holds the constants IO_SEL = 2'b11, IO_UART = 18'h30000 and IO_CLK = 18'h30004.
  - It also holds the byte-offset constants for the snapshot bytes and the DataLength width define shared with cpu.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH).
  - Provides push, pop, dout, full, empty and count; it is instantiated twice, once for TX and once for RX.
- The RAM array, decode logic and counter live in the top module.

Test Plan:
- RAM write then read:
  - Stimulus: write 0xA5 to 0x00010 at cycle t, then read 0x00010 at t+1.
  - Required: mem_din == 0xA5 at t+2. A read of 0x00011 returns its preloaded value one cycle later.
- UART out:
  - Stimulus: write 0x48, then 0x00, then 0x49 to 0x30000 with tx_ready = 1.
  - Required: tx_data shows 0x48 then 0x49 only; the zero byte is never enqueued.
- Backpressure:
  - Stimulus: tx_ready = 0, then 6 writes to 0x30000 (TX_DEPTH = 8).
  - Required: io_buffer_full rises on the cycle after the 6th push.
  - Stimulus: 3 more writes.
  - Required: the 9th byte is dropped and tx_overflow = 1.
  - Stimulus: release tx_ready.
  - Required: 8 bytes drain in order.
- Clock read:
  - Stimulus: after reset, read 0x30004 at cycle 300, then 0x30005, 0x30006, 0x30007 on the following cycles.
  - Required: the four bytes reassemble to the counter value latched at cycle 300, unaffected by later increments.
- UART in:
  - Stimulus: push 0x31 and 0x32 via rx_valid, then read 0x30000 three times.
  - Required: mem_din returns 0x31, then 0x32, then 0x00.
- Halt:
  - Stimulus: write any value to 0x30004.
  - Required: halted = 1, tx_data = 0x00 is emitted, the counter freezes, and a RAM read still returns data.
  - Stimulus: assert rst_in.
  - Required: halted and the counter return to 0.
